// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; a 1-bit floor keeps degenerate widths legal.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mul_absval.sv
// Two's-complement operand to unsigned magnitude plus sign bit.
// The most negative value maps to 2^(WIDTH-1), which still fits WIDTH unsigned bits.
module seq_mul_absval #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_sign
);

  assign o_sign = i_val[WIDTH-1];
  assign o_mag  = o_sign ? ((~i_val) + WIDTH'(1)) : i_val;

endmodule

// File: rtl/seq_multiplier.sv
// Handshaked shift-and-add multiplier: one partial-product bit per cycle, WIDTH cycles per product.
// Define SEQ_MUL_SIGNED_EN to add the sgn port and two's-complement operand support.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               busy
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [PW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_out_valid;
  logic [PW-1:0]      r_z;

  logic [WIDTH-1:0]   w_x_op;
  logic [WIDTH-1:0]   w_y_op;
  logic               w_neg;
  logic [WIDTH:0]     w_sum;
  logic [PW-1:0]      w_acc_next;
  logic [PW-1:0]      w_z_final;
  logic               w_last;

`ifdef SEQ_MUL_SIGNED_EN
  logic [WIDTH-1:0]   w_x_mag;
  logic [WIDTH-1:0]   w_y_mag;
  logic               w_x_sign;
  logic               w_y_sign;

  seq_mul_absval #(.WIDTH(WIDTH)) u_abs_x (.i_val(x), .o_mag(w_x_mag), .o_sign(w_x_sign));
  seq_mul_absval #(.WIDTH(WIDTH)) u_abs_y (.i_val(y), .o_mag(w_y_mag), .o_sign(w_y_sign));

  assign w_x_op = sgn ? w_x_mag : x;
  assign w_y_op = sgn ? w_y_mag : y;
  assign w_neg  = sgn & (w_x_sign ^ w_y_sign);
`else
  assign w_x_op = x;
  assign w_y_op = y;
  assign w_neg  = 1'b0;
`endif

  // Upper half of the accumulator plus the gated multiplicand; the carry becomes the new MSB.
  assign w_sum      = {1'b0, r_acc[PW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_z_final  = r_neg ? (-w_acc_next) : w_acc_next;
  assign w_last     = (r_state == RUN) && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: the multiplier occupies the low half of the accumulator and shifts out as the product shifts in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
      r_z         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand <= w_x_op;
            r_acc   <= {{WIDTH{1'b0}}, w_y_op};
            r_cnt   <= CW'(WIDTH - 1);
            r_neg   <= w_neg;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_z         <= w_z_final;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign z         = r_z;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH 4, 8 and 16 against a cycle-level behavioural model.
module tb_seq_multiplier;

`ifdef SEQ_MUL_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] zexp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done_f [3];

  task automatic check(input string nm, input int w, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s W=%0d got=%h exp=%h t=%0t", nm, w, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W  = (gi == 0) ? 4 : (gi == 1) ? 8 : 16;
    localparam int PW = 2 * W;

    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          sgn;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [PW-1:0] z;

    int            m_run  = 0;
    bit            m_done = 1'b0;
    logic [PW-1:0] m_z    = '0;
    logic [PW-1:0] m_pend = '0;
    int            n_hs   = 0;
    int            n_ops  = 0;

    seq_multiplier #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
`ifdef SEQ_MUL_SIGNED_EN
      .sgn       (sgn),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .busy      (busy)
    );

    // Reference product in plain integer arithmetic, truncated to 2*W bits.
    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
      longint av = longint'(a);
      longint bv = longint'(b);
      if (s && a[W-1]) av = av - (longint'(1) << W);
      if (s && b[W-1]) bv = bv - (longint'(1) << W);
      return PW'(av * bv);
    endfunction

    // Model: an accept starts a W-cycle countdown, then the result waits for out_ready.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_run  <= 0;
        m_done <= 1'b0;
        m_z    <= '0;
      end else if (m_done) begin
        if (out_ready) m_done <= 1'b0;
      end else if (m_run > 0) begin
        m_run <= m_run - 1;
        if (m_run == 1) begin
          m_done <= 1'b1;
          m_z    <= m_pend;
        end
      end else if (in_valid) begin
        m_run  <= W;
        m_pend <= ref_prod(x, y, sgn & SGN_EN);
      end
    end

    always @(posedge clk) begin
      if (!rst && out_valid && out_ready) n_hs++;
    end

    always @(negedge clk) begin
      check("in_ready",  W, 32'(in_ready),  32'(!m_done && (m_run == 0)));
      check("busy",      W, 32'(busy),      32'(m_done || (m_run != 0)));
      check("out_valid", W, 32'(out_valid), 32'(m_done));
      check("z",         W, 32'(z),         32'(m_z));
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input int hold, input bit poke, output logic [PW-1:0] zr);
      int t;
      zr       = '0;
      x        = a;
      y        = b;
      sgn      = s;
      in_valid = 1'b1;
      if (hold < 0) out_ready = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", W, 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x        = W'($urandom);
      y        = W'($urandom);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < W + 4) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", W, 32'(out_valid), 32'd1);
        return;
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        if (poke) begin
          in_valid = 1'b1;
          x        = W'($urandom);
          y        = W'($urandom);
        end
        repeat (hold) @(negedge clk);
      end
      zr        = z;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      n_ops++;
    endtask

    initial begin
      vec_t          dir [$];
      logic [PW-1:0] zr;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      bit            s;
      int            hold;
      int            r;

      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      y         = '0;
      sgn       = 1'b0;
      rst       = 1'b0;
      #1 rst    = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst    = 1'b0;

      case (W)
        4: begin
          dir.push_back('{32'd15, 32'd15, 1'b0, 32'd225});
          dir.push_back('{32'd0, 32'd9, 1'b0, 32'd0});
`ifdef SEQ_MUL_SIGNED_EN
          dir.push_back('{32'h8, 32'h8, 1'b1, 32'h40});
          dir.push_back('{32'hF, 32'h7, 1'b1, 32'hF9});
`endif
        end
        8: begin
          dir.push_back('{32'd0, 32'd200, 1'b0, 32'd0});
          dir.push_back('{32'd255, 32'd255, 1'b0, 32'd65025});
`ifdef SEQ_MUL_SIGNED_EN
          dir.push_back('{32'h80, 32'h80, 1'b1, 32'd16384});
          dir.push_back('{32'hFD, 32'h05, 1'b1, 32'hFFF1});
`endif
        end
        default: begin
          dir.push_back('{32'd65535, 32'd65535, 1'b0, 32'hFFFE0001});
          dir.push_back('{32'd1234, 32'd5678, 1'b0, 32'd7006652});
        end
      endcase

      // Hand-computed products; the first runs with out_ready already high.
      foreach (dir[i]) begin
        do_op(W'(dir[i].a), W'(dir[i].b), dir[i].s, (i == 0) ? -1 : 0, 1'b0, zr);
        check("directed_z", W, 32'(zr), dir[i].zexp);
      end

      // Random operands with random consumer back-pressure.
      for (int i = 0; i < 30; i++) begin
        a    = W'($urandom);
        b    = W'($urandom);
        s    = SGN_EN && ($urandom_range(0, 1) == 1);
        r    = int'($urandom_range(0, 4));
        hold = (r == 4) ? -1 : r;
        do_op(a, b, s, hold, 1'b0, zr);
        check("rand_z", W, 32'(zr), 32'(ref_prod(a, b, s)));
      end

      // Result held for 10 cycles while a producer pushes operands that must be ignored.
      do_op(W'(3), W'(5), 1'b0, 10, 1'b1, zr);
      check("backpressure_z", W, 32'(zr), 32'd15);

      // Reset mid-run discards the pending product and clears outputs at once.
      x        = W'(5);
      y        = W'(3);
      sgn      = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_in_ready",  W, 32'(in_ready),  32'd1);
      check("rst_busy",      W, 32'(busy),      32'd0);
      check("rst_out_valid", W, 32'(out_valid), 32'd0);
      check("rst_z",         W, 32'(z),         32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      do_op(W'(7), W'(6), 1'b0, 0, 1'b0, zr);
      check("after_rst_z", W, 32'(zr), 32'd42);

      repeat (2) @(negedge clk);
      check("handshakes", W, 32'(n_hs), 32'(n_ops));
      done_f[gi] = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(done_f[0] && done_f[1] && done_f[2]) && t < 20000) begin
      #10;
      t++;
    end
    if (!(done_f[0] && done_f[1] && done_f[2])) begin
      checks++;
      errors++;
      $display("FAIL run_timeout got=%0d%0d%0d exp=111", done_f[0], done_f[1], done_f[2]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
